desc_cnt_array: RTL and testbench
=================================

# desc_cnt_array

Multi-queue descriptor credit tracker for the QDMA user logic: holds one available-descriptor count per queue for `NUM_Q` queues, accepting one increment, one multi-descriptor decrement and one clear per cycle on independent queue IDs. It drives a per-queue ready vector against a programmable threshold, a registered count read-back port, and error pulses. It sits between the descriptor-credit interface and the per-queue DMA request generators, replacing the per-queue single-counter instances.

## Interface
- `NUM_Q`, 16: number of queues; must be at least 2.
- `QID_WIDTH`, 4: queue ID width; must satisfy 2^`QID_WIDTH` ≥ `NUM_Q`.
- `DESC_CNT_WIDTH`, 16: width of each per-queue count.
- `DESC_AVAIL_WIDTH`, 8: width of the increment value.
- `DEC_WIDTH`, 4: width of the decrement amount, so up to 15 descriptors per decrement.
- `RDY_THRESH`, 1: minimum count at which a queue reports ready; range 1 to 2^`DESC_CNT_WIDTH`-1.

Ports:
- `user_clk` in 1: clock; all logic is on the rising edge.
- `user_reset` in 1: synchronous, active-high reset.
- `inc_vld` in 1: increment strobe.
- `inc_qid` in `QID_WIDTH`: queue to increment.
- `inc_val` in `DESC_AVAIL_WIDTH`: amount to add.
- `dec_vld` in 1: decrement strobe.
- `dec_qid` in `QID_WIDTH`: queue to decrement.
- `dec_num` in `DEC_WIDTH`: number of descriptors consumed; 0 is legal and is a no-op.
- `clr_vld` in 1: clear strobe for one queue.
- `clr_qid` in `QID_WIDTH`: queue to clear.
- `clr_all` in 1: clear every queue.
- `rd_qid` in `QID_WIDTH`: read-back select.
- `rd_cnt` out `DESC_CNT_WIDTH`: registered count of queue `rd_qid`.
- `desc_rdy` out `NUM_Q`: per-queue ready indication, look-ahead masked.
- `dec_err` out 1: one-cycle pulse on decrement underflow.
- `ovf_err` out 1: one-cycle pulse on saturation; present only with the macro.

## Operation
Each cycle, each queue q computes its next count in `DESC_CNT_WIDTH`+2 signed bits:
- next = cnt[q] + (`inc_vld` && `inc_qid`==q ? `inc_val` : 0) − (`dec_vld` && `dec_qid`==q ? `dec_num` : 0).

Update rules:
- **Clear priority:** if `clr_all`, or `clr_vld` with `clr_qid`==q, then next = 0 and any inc/dec to q that cycle is dropped. Operations on other queues proceed normally.
- **Underflow:** if next < 0, the count becomes 0 and `dec_err` pulses the following cycle. A same-cycle increment is still credited before the clamp, so the result is max(0, cnt+inc−dec).
- **Overflow:** if next > 2^`DESC_CNT_WIDTH`−1, behaviour depends on the Configuration macro.
- **Out-of-range IDs:** any strobe whose QID is ≥ `NUM_Q` is ignored. It produces no error and no state change.
- **Ready:** `desc_rdy[q]` = (cnt[q] ≥ `RDY_THRESH`) && !(`dec_vld` && `dec_qid`==q && cnt[q]−`dec_num` < `RDY_THRESH`) && !(clear of q this cycle).
  - The mask is combinational on the dec/clr inputs.
  - The mask does not credit a same-cycle increment; ready returns one cycle later.
- **Read-back:** `rd_cnt` is registered from the next-state value of queue `rd_qid`. It therefore includes all updates applied at the same edge.
  - An out-of-range `rd_qid` returns 0.

## Timing
- **Reset:** while `user_reset` is high at an edge, every count goes to 0 and `rd_cnt`=0, `dec_err`=0, `ovf_err`=0.
  - `desc_rdy` is 0 because the counts are 0.
  - Inputs are ignored during reset; a strobe on the same edge as reset is discarded.
- **Count latency:** an inc/dec/clr sampled at edge N is visible in cnt[q] and `rd_cnt` after edge N.
- **Ready latency:** rising `desc_rdy` appears after edge N. Falling `desc_rdy` is immediate, in the same cycle as the `dec_vld`/clear strobe.
- **Error pulses:** `dec_err` and `ovf_err` are registered and assert for exactly the cycle after the offending edge. They are the OR over all queues.
- **No stalls:** all ports accept one operation every cycle; there is no backpressure.

## Configuration
- `DESC_CNT_SAT_EN` defined:
  - Overflowing counts saturate at 2^`DESC_CNT_WIDTH`−1.
  - `ovf_err` pulses one cycle after the overflow.
- `DESC_CNT_SAT_EN` undefined:
  - Counts wrap modulo 2^`DESC_CNT_WIDTH`.
  - The `ovf_err` port and its logic are not present.
  - Underflow clamping and `dec_err` are unaffected by the macro.

## Test plan
- **Reset:** reset for 2 cycles, then read all queues → every `rd_cnt`=0, `desc_rdy`=0, no error pulses.
- **Basic inc/dec (`RDY_THRESH`=1):** inc q3 by 5 → `rd_cnt`(q3)=5 and `desc_rdy[3]`=1 next cycle. Then dec q3 by 5 → `desc_rdy[3]` drops in the same cycle and the count is 0 after the edge.
- **Same-queue inc and dec:** q7=2; in one cycle inc q7 by 4 and dec q7 by 6 → count 0, no `dec_err`. Next cycle dec q7 by 1 → count stays 0 and `dec_err` pulses once.
- **Clear priority:** q1=10 and q2=10; in one cycle `clr_vld` q1, inc q1 by 3, dec q2 by 4 → q1=0, q2=6.
- **Overflow (`DESC_CNT_WIDTH`=16):** q0=0xFFF0, inc q0 by 0x20 → 0xFFFF with an `ovf_err` pulse when the macro is defined; 0x0010 when it is not.
- **Threshold and out-of-range IDs (`RDY_THRESH`=4, `NUM_Q`=12):** inc q5 by 3 → `desc_rdy[5]`=0; inc q5 by 1 → 1. Inc q13 by 9 → no state change and no error.

Source files
------------

// File: rtl/desc_cnt_array.sv
// Per-queue descriptor credit counters with look-ahead ready mask and registered read-back.
// Define DESC_CNT_SAT_EN to saturate on overflow and expose ovf_err; otherwise counts wrap.
module desc_cnt_array #(
    parameter int unsigned NUM_Q            = 16,
    parameter int unsigned QID_WIDTH        = 4,
    parameter int unsigned DESC_CNT_WIDTH   = 16,
    parameter int unsigned DESC_AVAIL_WIDTH = 8,
    parameter int unsigned DEC_WIDTH        = 4,
    parameter int unsigned RDY_THRESH       = 1
) (
    input  logic                      user_clk,
    input  logic                      user_reset,
    input  logic                      inc_vld,
    input  logic [QID_WIDTH-1:0]      inc_qid,
    input  logic [DESC_AVAIL_WIDTH-1:0] inc_val,
    input  logic                      dec_vld,
    input  logic [QID_WIDTH-1:0]      dec_qid,
    input  logic [DEC_WIDTH-1:0]      dec_num,
    input  logic                      clr_vld,
    input  logic [QID_WIDTH-1:0]      clr_qid,
    input  logic                      clr_all,
    input  logic [QID_WIDTH-1:0]      rd_qid,
    output logic [DESC_CNT_WIDTH-1:0] rd_cnt,
    output logic [NUM_Q-1:0]          desc_rdy,
    output logic                      dec_err
`ifdef DESC_CNT_SAT_EN
    ,
    output logic                      ovf_err
`endif
);

    // Two extra bits: one for carry past the count width, one as sign for underflow.
    localparam int unsigned NextW = DESC_CNT_WIDTH + 2;
    localparam logic [DESC_CNT_WIDTH-1:0] Thresh = DESC_CNT_WIDTH'(RDY_THRESH);

    logic [NUM_Q-1:0][DESC_CNT_WIDTH-1:0] cnt_q;
    logic [NUM_Q-1:0][DESC_CNT_WIDTH-1:0] cnt_d;
    logic [NUM_Q-1:0]                     under_vec;
    logic [DESC_CNT_WIDTH-1:0]            rd_cnt_d;
`ifdef DESC_CNT_SAT_EN
    logic [NUM_Q-1:0]                     over_vec;
`endif

    for (genvar g = 0; g < NUM_Q; g++) begin : g_q
        logic             inc_hit;
        logic             dec_hit;
        logic             clr_hit;
        logic             neg;
        logic [NextW-1:0] sum;

        // IDs >= NUM_Q never match any g, so out-of-range strobes fall away here.
        assign inc_hit = inc_vld && (inc_qid == QID_WIDTH'(g));
        assign dec_hit = dec_vld && (dec_qid == QID_WIDTH'(g));
        assign clr_hit = clr_all || (clr_vld && (clr_qid == QID_WIDTH'(g)));

        assign sum = NextW'(cnt_q[g])
                   + (inc_hit ? NextW'(inc_val) : '0)
                   - (dec_hit ? NextW'(dec_num) : '0);
        assign neg = sum[NextW-1];
        assign under_vec[g] = !clr_hit && neg;

`ifdef DESC_CNT_SAT_EN
        logic ovf;
        assign ovf = !neg && sum[DESC_CNT_WIDTH];
        assign over_vec[g] = !clr_hit && ovf;
        assign cnt_d[g] = (clr_hit || neg) ? '0 :
                          ovf              ? '1 : sum[DESC_CNT_WIDTH-1:0];
`else
        logic unused_carry;
        assign unused_carry = sum[DESC_CNT_WIDTH];
        assign cnt_d[g] = (clr_hit || neg) ? '0 : sum[DESC_CNT_WIDTH-1:0];
`endif

        // Falling edge is look-ahead on dec/clr; a same-cycle increment is not credited.
        assign desc_rdy[g] = (cnt_q[g] >= Thresh)
                          && !(dec_hit && (NextW'(cnt_q[g]) < NextW'(Thresh) + NextW'(dec_num)))
                          && !clr_hit;
    end

    always_comb begin
        rd_cnt_d = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            if (rd_qid == QID_WIDTH'(q)) begin
                rd_cnt_d = cnt_d[q];
            end
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            cnt_q   <= '0;
            rd_cnt  <= '0;
            dec_err <= 1'b0;
`ifdef DESC_CNT_SAT_EN
            ovf_err <= 1'b0;
`endif
        end else begin
            cnt_q   <= cnt_d;
            rd_cnt  <= rd_cnt_d;
            dec_err <= |under_vec;
`ifdef DESC_CNT_SAT_EN
            ovf_err <= |over_vec;
`endif
        end
    end

endmodule

// File: tb/tb_desc_cnt_array.sv
// Bench for desc_cnt_array: a default instance (16 queues, threshold 1) and a
// 12-queue threshold-4 instance sharing the same stimulus, checked phase by phase.
module tb_desc_cnt_array;

    typedef struct {
        logic        iv;
        logic [3:0]  iq;
        logic [7:0]  ival;
        logic        dv;
        logic [3:0]  dq;
        logic [3:0]  dn;
        logic        cv;
        logic [3:0]  cq;
        logic        ca;
        logic [3:0]  rq;
        logic [15:0] rdy;
        logic [15:0] cnt;
        logic        derr;
    } vec_t;

    typedef struct {
        logic [15:0] cnt;
        logic        derr;
        logic        oerr;
    } exp_t;

    logic        user_clk = 1'b0;
    logic        user_reset = 1'b1;
    logic        inc_vld = 1'b0;
    logic [3:0]  inc_qid = '0;
    logic [7:0]  inc_val = '0;
    logic        dec_vld = 1'b0;
    logic [3:0]  dec_qid = '0;
    logic [3:0]  dec_num = '0;
    logic        clr_vld = 1'b0;
    logic [3:0]  clr_qid = '0;
    logic        clr_all = 1'b0;
    logic [3:0]  rd_qid = '0;

    logic [15:0] rd_cnt_a;
    logic [15:0] rdy_a;
    logic        derr_a;
    logic [15:0] rd_cnt_b;
    logic [11:0] rdy_b;
    logic        derr_b;
`ifdef DESC_CNT_SAT_EN
    logic        oerr_a;
    logic        oerr_b;
`endif

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];
    vec_t vec_a[17];
    vec_t vec_b[12];

    always #5 user_clk = ~user_clk;

    desc_cnt_array u_dut_a (
        .user_clk   (user_clk),
        .user_reset (user_reset),
        .inc_vld    (inc_vld),
        .inc_qid    (inc_qid),
        .inc_val    (inc_val),
        .dec_vld    (dec_vld),
        .dec_qid    (dec_qid),
        .dec_num    (dec_num),
        .clr_vld    (clr_vld),
        .clr_qid    (clr_qid),
        .clr_all    (clr_all),
        .rd_qid     (rd_qid),
        .rd_cnt     (rd_cnt_a),
        .desc_rdy   (rdy_a),
        .dec_err    (derr_a)
`ifdef DESC_CNT_SAT_EN
        ,
        .ovf_err    (oerr_a)
`endif
    );

    desc_cnt_array #(
        .NUM_Q      (12),
        .RDY_THRESH (4)
    ) u_dut_b (
        .user_clk   (user_clk),
        .user_reset (user_reset),
        .inc_vld    (inc_vld),
        .inc_qid    (inc_qid),
        .inc_val    (inc_val),
        .dec_vld    (dec_vld),
        .dec_qid    (dec_qid),
        .dec_num    (dec_num),
        .clr_vld    (clr_vld),
        .clr_qid    (clr_qid),
        .clr_all    (clr_all),
        .rd_qid     (rd_qid),
        .rd_cnt     (rd_cnt_b),
        .desc_rdy   (rdy_b),
        .dec_err    (derr_b)
`ifdef DESC_CNT_SAT_EN
        ,
        .ovf_err    (oerr_b)
`endif
    );

    function automatic vec_t mk(logic iv, logic [3:0] iq, logic [7:0] ival,
                                logic dv, logic [3:0] dq, logic [3:0] dn,
                                logic cv, logic [3:0] cq, logic ca, logic [3:0] rq,
                                logic [15:0] rdy, logic [15:0] cnt, logic derr);
        vec_t v;
        v.iv = iv; v.iq = iq; v.ival = ival;
        v.dv = dv; v.dq = dq; v.dn = dn;
        v.cv = cv; v.cq = cq; v.ca = ca; v.rq = rq;
        v.rdy = rdy; v.cnt = cnt; v.derr = derr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        inc_vld = 1'b0; inc_qid = '0; inc_val = '0;
        dec_vld = 1'b0; dec_qid = '0; dec_num = '0;
        clr_vld = 1'b0; clr_qid = '0; clr_all = 1'b0;
    endtask

    // Drive one cycle, check the combinational ready mask, then compare registered outputs.
    task automatic apply(input vec_t v, input bit use_b, input logic oerr_exp, input string tag);
        exp_t e;
        @(negedge user_clk);
        inc_vld = v.iv; inc_qid = v.iq; inc_val = v.ival;
        dec_vld = v.dv; dec_qid = v.dq; dec_num = v.dn;
        clr_vld = v.cv; clr_qid = v.cq; clr_all = v.ca;
        rd_qid  = v.rq;
        #1;
        check($sformatf("%s rdy", tag), use_b ? {20'b0, rdy_b} : {16'b0, rdy_a}, {16'b0, v.rdy});
        sb.push_back('{cnt: v.cnt, derr: v.derr, oerr: oerr_exp});
        @(posedge user_clk);
        #1;
        e = sb.pop_front();
        check($sformatf("%s rd_cnt", tag), use_b ? {16'b0, rd_cnt_b} : {16'b0, rd_cnt_a},
              {16'b0, e.cnt});
        check($sformatf("%s dec_err", tag), {31'b0, use_b ? derr_b : derr_a}, {31'b0, e.derr});
`ifdef DESC_CNT_SAT_EN
        check($sformatf("%s ovf_err", tag), {31'b0, use_b ? oerr_b : oerr_a}, {31'b0, e.oerr});
`endif
    endtask

    // Reset for two edges with a stray increment that must be discarded.
    task automatic do_reset();
        @(negedge user_clk);
        user_reset = 1'b1;
        inc_vld = 1'b1; inc_qid = 4'd3; inc_val = 8'd9; rd_qid = 4'd3;
        repeat (2) @(posedge user_clk);
        @(negedge user_clk);
        user_reset = 1'b0;
        set_idle();
        #1;
        check("reset rdy_a", {16'b0, rdy_a}, 32'h0);
        check("reset rdy_b", {20'b0, rdy_b}, 32'h0);
        check("reset rd_cnt_a", {16'b0, rd_cnt_a}, 32'h0);
        check("reset rd_cnt_b", {16'b0, rd_cnt_b}, 32'h0);
        check("reset dec_err_a", {31'b0, derr_a}, 32'h0);
`ifdef DESC_CNT_SAT_EN
        check("reset ovf_err_a", {31'b0, oerr_a}, 32'h0);
`endif
    endtask

    initial begin
        logic [15:0] acc;
        logic [15:0] ovf_cnt;

        //               iv iq ival   dv dq dn  cv cq ca  rq  rdy       cnt  derr
        vec_a[0]  = mk(1, 3, 5,     0, 0, 0,  0, 0, 0,  3,  16'h0000, 5,  0);
        vec_a[1]  = mk(0, 0, 0,     0, 0, 0,  0, 0, 0,  3,  16'h0008, 5,  0);
        vec_a[2]  = mk(0, 0, 0,     1, 3, 5,  0, 0, 0,  3,  16'h0000, 0,  0);
        vec_a[3]  = mk(0, 0, 0,     0, 0, 0,  0, 0, 0,  3,  16'h0000, 0,  0);
        vec_a[4]  = mk(1, 7, 2,     0, 0, 0,  0, 0, 0,  7,  16'h0000, 2,  0);
        vec_a[5]  = mk(1, 7, 4,     1, 7, 6,  0, 0, 0,  7,  16'h0000, 0,  0);
        vec_a[6]  = mk(0, 0, 0,     1, 7, 1,  0, 0, 0,  7,  16'h0000, 0,  1);
        vec_a[7]  = mk(0, 0, 0,     0, 0, 0,  0, 0, 0,  7,  16'h0000, 0,  0);
        vec_a[8]  = mk(1, 1, 10,    0, 0, 0,  0, 0, 0,  1,  16'h0000, 10, 0);
        vec_a[9]  = mk(1, 2, 10,    0, 0, 0,  0, 0, 0,  2,  16'h0002, 10, 0);
        vec_a[10] = mk(1, 1, 3,     1, 2, 4,  1, 1, 0,  1,  16'h0004, 0,  0);
        vec_a[11] = mk(0, 0, 0,     0, 0, 0,  0, 0, 0,  2,  16'h0004, 6,  0);
        vec_a[12] = mk(0, 0, 0,     1, 2, 0,  0, 0, 0,  2,  16'h0004, 6,  0);
        vec_a[13] = mk(1, 2, 1,     0, 0, 0,  0, 0, 1,  2,  16'h0000, 0,  0);
        vec_a[14] = mk(1, 4, 3,     1, 5, 2,  0, 0, 0,  4,  16'h0000, 3,  1);
        vec_a[15] = mk(0, 0, 0,     0, 0, 0,  0, 0, 0,  5,  16'h0010, 0,  0);
        vec_a[16] = mk(0, 0, 0,     0, 0, 0,  0, 0, 1,  4,  16'h0000, 0,  0);

        vec_b[0]  = mk(1, 5, 3,     0, 0, 0,  0, 0, 0,  5,  16'h0000, 3,  0);
        vec_b[1]  = mk(0, 0, 0,     0, 0, 0,  0, 0, 0,  5,  16'h0000, 3,  0);
        vec_b[2]  = mk(1, 5, 1,     0, 0, 0,  0, 0, 0,  5,  16'h0000, 4,  0);
        vec_b[3]  = mk(0, 0, 0,     0, 0, 0,  0, 0, 0,  5,  16'h0020, 4,  0);
        vec_b[4]  = mk(1, 13, 9,    0, 0, 0,  0, 0, 0,  13, 16'h0020, 0,  0);
        vec_b[5]  = mk(0, 0, 0,     1, 13, 15, 0, 0, 0, 5,  16'h0020, 4,  0);
        vec_b[6]  = mk(0, 0, 0,     0, 0, 0,  1, 12, 0, 5,  16'h0020, 4,  0);
        vec_b[7]  = mk(0, 0, 0,     1, 5, 1,  0, 0, 0,  5,  16'h0000, 3,  0);
        vec_b[8]  = mk(0, 0, 0,     0, 0, 0,  0, 0, 0,  13, 16'h0000, 0,  0);
        vec_b[9]  = mk(1, 5, 1,     0, 0, 0,  0, 0, 0,  5,  16'h0000, 4,  0);
        vec_b[10] = mk(0, 0, 0,     0, 0, 0,  0, 0, 0,  5,  16'h0020, 4,  0);
        vec_b[11] = mk(0, 0, 0,     0, 0, 0,  1, 5, 0,  5,  16'h0000, 0,  0);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'(i), 16'h0, 16'h0, 1'b0), 1'b0, 1'b0,
                  $sformatf("read_all q%0d", i));
        end

        for (int i = 0; i < 17; i++) begin
            apply(vec_a[i], 1'b0, 1'b0, $sformatf("vec_a[%0d]", i));
        end

        // Fill q0 to 0xFFF0 then push it past the top.
        acc = 16'h0;
        for (int k = 0; k < 256; k++) begin
            acc = acc + 16'h00FF;
            apply(mk(1, 0, 8'hFF, 0, 0, 0, 0, 0, 0, 0, (k == 0) ? 16'h0 : 16'h1, acc, 1'b0),
                  1'b0, 1'b0, $sformatf("fill %0d", k));
        end
        apply(mk(1, 0, 8'hF0, 0, 0, 0, 0, 0, 0, 0, 16'h1, 16'hFFF0, 1'b0), 1'b0, 1'b0,
              "fill last");
`ifdef DESC_CNT_SAT_EN
        ovf_cnt = 16'hFFFF;
        apply(mk(1, 0, 8'h20, 0, 0, 0, 0, 0, 0, 0, 16'h1, ovf_cnt, 1'b0), 1'b0, 1'b1, "overflow");
`else
        ovf_cnt = 16'h0010;
        apply(mk(1, 0, 8'h20, 0, 0, 0, 0, 0, 0, 0, 16'h1, ovf_cnt, 1'b0), 1'b0, 1'b0, "overflow");
`endif
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h1, ovf_cnt, 1'b0), 1'b0, 1'b0, "post overflow");

        do_reset();
        for (int i = 0; i < 12; i++) begin
            apply(vec_b[i], 1'b1, 1'b0, $sformatf("vec_b[%0d]", i));
        end

        @(negedge user_clk);
        set_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
